// File: rtl/mmio_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the downstream
// memory/IO strobes; fsm_state exposes the arbiter FSM for observation.
interface mmio_arbiter_if;
  // Handshake: a master raises req and holds it with stable fields until its
  // one-cycle ack; fields are sampled only while the arbiter is idle.
  logic        m0_req, m1_req;
  logic        m0_we, m1_we;
  logic        m0_re, m1_re;
  logic        m0_signed, m1_signed;
  logic [31:0] m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_gnt, m1_gnt;
  logic        m0_ack, m1_ack;
  logic [31:0] m0_rdata, m1_rdata;
  logic        MemRead, MemWrite, ioRead, ioWrite;
  logic        is_signed;
  logic [31:0] addr_out;
  logic [31:0] din_out;
  logic [31:0] dout_in;
  logic [1:0]  fsm_state;

  modport slave (
    input  m0_req, m1_req, m0_we, m1_we, m0_re, m1_re, m0_signed, m1_signed,
    input  m0_addr, m1_addr, m0_wdata, m1_wdata, dout_in,
    output m0_gnt, m1_gnt, m0_ack, m1_ack, m0_rdata, m1_rdata,
    output MemRead, MemWrite, ioRead, ioWrite, is_signed, addr_out, din_out,
    output fsm_state
  );

  modport master (
    output m0_req, m1_req, m0_we, m1_we, m0_re, m1_re, m0_signed, m1_signed,
    output m0_addr, m1_addr, m0_wdata, m1_wdata, dout_in,
    input  m0_gnt, m1_gnt, m0_ack, m1_ack, m0_rdata, m1_rdata,
    input  MemRead, MemWrite, ioRead, ioWrite, is_signed, addr_out, din_out,
    input  fsm_state
  );
endinterface

// File: rtl/mmio_arbiter.sv
// Round-robin two-master arbiter for the shared memory/IO port: latches one
// request, drives registered strobes for a fixed length, returns data with ack.
module mmio_arbiter #(
  parameter int          RD_LAT  = 1,
  parameter logic [15:0] IO_BASE = 16'hFFFF
) (
  input logic          clk,
  input logic          rst,
  mmio_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [3:0] LAT4 = 4'(RD_LAT);

  state_t      state, state_nxt;
  logic        last, last_nxt;
  logic        win, win_nxt;
  logic        op_we, op_we_nxt;
  logic        op_re, op_re_nxt;
  logic        sgn_nxt;
  logic [31:0] addr_nxt, din_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        cap_rd;
  logic        io_nxt, rd_nxt, wr_nxt;

  assign bus.fsm_state = state;

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    win_nxt   = win;
    op_we_nxt = op_we;
    op_re_nxt = op_re;
    sgn_nxt   = bus.is_signed;
    addr_nxt  = bus.addr_out;
    din_nxt   = bus.din_out;
    cnt_nxt   = cnt;
    cap_rd    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.m0_req || bus.m1_req) begin
          // Under contention the master not served last wins.
          win_nxt = (bus.m0_req && bus.m1_req) ? ~last : bus.m1_req;
          if (win_nxt) begin
            op_we_nxt = bus.m1_we;
            op_re_nxt = bus.m1_re && !bus.m1_we;
            sgn_nxt   = bus.m1_signed;
            addr_nxt  = bus.m1_addr;
            din_nxt   = bus.m1_wdata;
          end else begin
            op_we_nxt = bus.m0_we;
            op_re_nxt = bus.m0_re && !bus.m0_we;
            sgn_nxt   = bus.m0_signed;
            addr_nxt  = bus.m0_addr;
            din_nxt   = bus.m0_wdata;
          end
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (op_re && LAT4 != 4'd0) begin
          state_nxt = WAIT;
          cnt_nxt   = LAT4 - 4'd1;
        end else begin
          state_nxt = RESP;
          cap_rd    = op_re;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt = RESP;
          cap_rd    = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP: begin
        last_nxt  = win;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Strobes are computed one cycle ahead so that they leave a flop.
    io_nxt = (addr_nxt[31:16] == IO_BASE);
    rd_nxt = op_re_nxt && (state_nxt == ISSUE || state_nxt == WAIT);
    wr_nxt = op_we_nxt && (state_nxt == ISSUE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      last          <= 1'b1;
      win           <= 1'b0;
      op_we         <= 1'b0;
      op_re         <= 1'b0;
      cnt           <= 4'd0;
      bus.is_signed <= 1'b0;
      bus.addr_out  <= 32'd0;
      bus.din_out   <= 32'd0;
      bus.MemRead   <= 1'b0;
      bus.MemWrite  <= 1'b0;
      bus.ioRead    <= 1'b0;
      bus.ioWrite   <= 1'b0;
      bus.m0_gnt    <= 1'b0;
      bus.m1_gnt    <= 1'b0;
      bus.m0_ack    <= 1'b0;
      bus.m1_ack    <= 1'b0;
      bus.m0_rdata  <= 32'd0;
      bus.m1_rdata  <= 32'd0;
    end else begin
      state         <= state_nxt;
      last          <= last_nxt;
      win           <= win_nxt;
      op_we         <= op_we_nxt;
      op_re         <= op_re_nxt;
      cnt           <= cnt_nxt;
      bus.is_signed <= sgn_nxt;
      bus.addr_out  <= addr_nxt;
      bus.din_out   <= din_nxt;
      bus.MemRead   <= rd_nxt && !io_nxt;
      bus.ioRead    <= rd_nxt && io_nxt;
      bus.MemWrite  <= wr_nxt && !io_nxt;
      bus.ioWrite   <= wr_nxt && io_nxt;
      bus.m0_gnt    <= (state_nxt != IDLE) && !win_nxt;
      bus.m1_gnt    <= (state_nxt != IDLE) && win_nxt;
      bus.m0_ack    <= (state_nxt == RESP) && !win_nxt;
      bus.m1_ack    <= (state_nxt == RESP) && win_nxt;
      if (cap_rd) begin
        if (win) bus.m1_rdata <= bus.dout_in;
        else     bus.m0_rdata <= bus.dout_in;
      end
    end
  end
endmodule
